// File: rtl/cpu7_csr_access.sv
// cpu7_csr_access
// CSR access initiator between ecl/exu and the CSR file.
//   _e stage: drives the combinational read address and decodes the op.
//   _m stage: holds the old CSR value for rd writeback and issues exactly one
//             masked write per retiring csrwr/csrxchg.
//   Stalls _e on a same-address read-after-write, and requests a refetch after
//   writes to CSRs that change fetch or interrupt state.
//
// Ports
//   clk, resetn                         clock, async active-low reset
//   ecl_csr_op_valid_e, ecl_csr_op_e    _e instruction valid / op (00 rd, 01 wr, 10 xchg, 11 = rd)
//   ecl_csr_num_e                       _e CSR number
//   exu_csr_rd_data_e, exu_csr_rj_data_e  new data / xchg mask
//   ecl_csr_kill_e, ecl_csr_kill_m      kill the _e / _m instruction
//   ecl_stall_m                         _m held this cycle
//   csr_raddr, csr_rdata                CSR file read port
//   csr_waddr, csr_wdata, csr_mask, csr_wen  CSR file write port
//   csr_ecl_rdata_m, csr_ecl_rdata_vld_m     old value for writeback, _m live
//   csr_ecl_stall_e                     _e must hold (RAW hazard)
//   csr_ecl_flush_m                     refetch after a flush-class write
module cpu7_csr_access #(
  parameter int GRLEN   = 32,
  parameter int CSR_BIT = 14
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ecl_csr_op_valid_e,
  input  logic [1:0]         ecl_csr_op_e,
  input  logic [CSR_BIT-1:0] ecl_csr_num_e,
  input  logic [GRLEN-1:0]   exu_csr_rd_data_e,
  input  logic [GRLEN-1:0]   exu_csr_rj_data_e,
  input  logic               ecl_csr_kill_e,
  input  logic               ecl_csr_kill_m,
  input  logic               ecl_stall_m,
  output logic [CSR_BIT-1:0] csr_raddr,
  input  logic [GRLEN-1:0]   csr_rdata,
  output logic [CSR_BIT-1:0] csr_waddr,
  output logic [GRLEN-1:0]   csr_wdata,
  output logic [GRLEN-1:0]   csr_mask,
  output logic               csr_wen,
  output logic [GRLEN-1:0]   csr_ecl_rdata_m,
  output logic               csr_ecl_rdata_vld_m,
  output logic               csr_ecl_stall_e,
  output logic               csr_ecl_flush_m
);

  localparam logic [CSR_BIT-1:0] CSR_CRMD   = CSR_BIT'(12'h000);
  localparam logic [CSR_BIT-1:0] CSR_ESTAT  = CSR_BIT'(12'h005);
  localparam logic [CSR_BIT-1:0] CSR_EENTRY = CSR_BIT'(12'h00c);
  localparam logic [CSR_BIT-1:0] CSR_TCFG   = CSR_BIT'(12'h041);
  localparam logic [CSR_BIT-1:0] CSR_TICLR  = CSR_BIT'(12'h044);

  logic               vld_m;
  logic               wr_m;
  logic               done_m;
  logic [CSR_BIT-1:0] waddr_m;
  logic [GRLEN-1:0]   wdata_m;
  logic [GRLEN-1:0]   mask_m;
  logic [GRLEN-1:0]   rdata_m;

  logic               wr_e;
  logic [GRLEN-1:0]   mask_e;
  logic               write_pending_m;
  logic               flush_addr_m;

  // Op decode; the reserved encoding falls through to plain read.
  always_comb begin
    wr_e   = 1'b0;
    mask_e = '0;
    case (ecl_csr_op_e)
      2'b01: begin
        wr_e   = 1'b1;
        mask_e = '1;
      end
      2'b10: begin
        wr_e   = 1'b1;
        mask_e = exu_csr_rj_data_e;
      end
      default: begin
        wr_e   = 1'b0;
        mask_e = '0;
      end
    endcase
  end

  // A held _m instruction that already wrote no longer blocks _e.
  assign write_pending_m = vld_m & wr_m & ~done_m;

  assign flush_addr_m = (waddr_m == CSR_CRMD)   | (waddr_m == CSR_ESTAT) |
                        (waddr_m == CSR_EENTRY) | (waddr_m == CSR_TCFG)  |
                        (waddr_m == CSR_TICLR);

  assign csr_raddr           = ecl_csr_num_e;
  assign csr_waddr           = waddr_m;
  assign csr_wdata           = wdata_m;
  assign csr_mask            = mask_m;
  assign csr_ecl_rdata_m     = rdata_m;
  assign csr_wen             = write_pending_m & ~ecl_csr_kill_m;
  assign csr_ecl_rdata_vld_m = vld_m & ~ecl_csr_kill_m;
  assign csr_ecl_stall_e     = ecl_csr_op_valid_e & write_pending_m &
                               (waddr_m == ecl_csr_num_e);
  assign csr_ecl_flush_m     = csr_wen & flush_addr_m;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_m   <= 1'b0;
      wr_m    <= 1'b0;
      done_m  <= 1'b0;
      waddr_m <= '0;
      wdata_m <= '0;
      mask_m  <= '0;
      rdata_m <= '0;
    end else if (!ecl_stall_m) begin
      // A stalled _e instruction enters _m as a bubble and re-reads later.
      vld_m   <= ecl_csr_op_valid_e & ~ecl_csr_kill_e & ~csr_ecl_stall_e;
      wr_m    <= wr_e;
      done_m  <= 1'b0;
      waddr_m <= ecl_csr_num_e;
      wdata_m <= exu_csr_rd_data_e;
      mask_m  <= mask_e;
      rdata_m <= csr_rdata;
    end else begin
      vld_m  <= vld_m & ~ecl_csr_kill_m;
      done_m <= done_m | csr_wen;
    end
  end

endmodule

// File: tb/tb_cpu7_csr_access.sv
// Self-checking bench for cpu7_csr_access. The bench owns a CSR file model
// (written only from the DUT write port) and a separate architectural copy
// updated by the reference model; directed cases are followed by random traffic.
module tb_cpu7_csr_access;
  localparam int GRLEN   = 32;
  localparam int CSR_BIT = 14;

  logic               clk = 1'b0;
  logic               resetn;
  logic               ecl_csr_op_valid_e;
  logic [1:0]         ecl_csr_op_e;
  logic [CSR_BIT-1:0] ecl_csr_num_e;
  logic [GRLEN-1:0]   exu_csr_rd_data_e;
  logic [GRLEN-1:0]   exu_csr_rj_data_e;
  logic               ecl_csr_kill_e;
  logic               ecl_csr_kill_m;
  logic               ecl_stall_m;
  logic [CSR_BIT-1:0] csr_raddr;
  logic [GRLEN-1:0]   csr_rdata;
  logic [CSR_BIT-1:0] csr_waddr;
  logic [GRLEN-1:0]   csr_wdata;
  logic [GRLEN-1:0]   csr_mask;
  logic               csr_wen;
  logic [GRLEN-1:0]   csr_ecl_rdata_m;
  logic               csr_ecl_rdata_vld_m;
  logic               csr_ecl_stall_e;
  logic               csr_ecl_flush_m;

  cpu7_csr_access #(.GRLEN(GRLEN), .CSR_BIT(CSR_BIT)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .ecl_csr_op_valid_e  (ecl_csr_op_valid_e),
    .ecl_csr_op_e        (ecl_csr_op_e),
    .ecl_csr_num_e       (ecl_csr_num_e),
    .exu_csr_rd_data_e   (exu_csr_rd_data_e),
    .exu_csr_rj_data_e   (exu_csr_rj_data_e),
    .ecl_csr_kill_e      (ecl_csr_kill_e),
    .ecl_csr_kill_m      (ecl_csr_kill_m),
    .ecl_stall_m         (ecl_stall_m),
    .csr_raddr           (csr_raddr),
    .csr_rdata           (csr_rdata),
    .csr_waddr           (csr_waddr),
    .csr_wdata           (csr_wdata),
    .csr_mask            (csr_mask),
    .csr_wen             (csr_wen),
    .csr_ecl_rdata_m     (csr_ecl_rdata_m),
    .csr_ecl_rdata_vld_m (csr_ecl_rdata_vld_m),
    .csr_ecl_stall_e     (csr_ecl_stall_e),
    .csr_ecl_flush_m     (csr_ecl_flush_m)
  );

  always #5 clk = ~clk;

  // CSR file as seen by the DUT, and the architectural state the model expects.
  logic [GRLEN-1:0] mem     [0:16383];
  logic [GRLEN-1:0] ref_csr [0:16383];
  assign csr_rdata = mem[csr_raddr];

  int n_chk  = 0;
  int n_fail = 0;
  int n_wen  = 0;

  // Model of the instruction sitting in _m.
  logic               m_live = 1'b0;
  logic               m_wr   = 1'b0;
  logic               m_done = 1'b0;
  logic [CSR_BIT-1:0] m_addr = '0;
  logic [GRLEN-1:0]   m_new  = '0;
  logic [GRLEN-1:0]   m_mask = '0;
  logic [GRLEN-1:0]   m_old  = '0;

  // What was presented this cycle and what the model expects of it.
  logic               e_valid = 1'b0;
  logic [1:0]         e_op    = 2'b00;
  logic [CSR_BIT-1:0] e_num   = '0;
  logic [GRLEN-1:0]   e_rd    = '0;
  logic [GRLEN-1:0]   e_rj    = '0;
  logic               e_ke    = 1'b0;
  logic               e_sm    = 1'b0;
  logic               exp_wen   = 1'b0;
  logic               exp_stall = 1'b0;

  logic [CSR_BIT-1:0] addrs [0:7];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_flush(input logic [CSR_BIT-1:0] a);
    return a == 14'h000 || a == 14'h005 || a == 14'h00c || a == 14'h041 || a == 14'h044;
  endfunction

  function automatic logic [GRLEN-1:0] op_mask(input logic [1:0] op, input logic [GRLEN-1:0] rj);
    if (op == 2'b01) return '1;
    if (op == 2'b10) return rj;
    return '0;
  endfunction

  // Drive one _e cycle and check every output against the model at negedge.
  task automatic cyc(input logic v, input logic [1:0] op, input logic [CSR_BIT-1:0] num,
                     input logic [GRLEN-1:0] rd, input logic [GRLEN-1:0] rj,
                     input logic ke, input logic km, input logic sm);
    ecl_csr_op_valid_e = v;  ecl_csr_op_e = op;  ecl_csr_num_e = num;
    exu_csr_rd_data_e  = rd; exu_csr_rj_data_e = rj;
    ecl_csr_kill_e = ke; ecl_csr_kill_m = km; ecl_stall_m = sm;
    e_valid = v; e_op = op; e_num = num; e_rd = rd; e_rj = rj; e_ke = ke; e_sm = sm;
    @(negedge clk);
    exp_wen   = m_live && m_wr && !m_done && !km;
    exp_stall = v && m_live && m_wr && !m_done && (m_addr == num);
    chk("raddr",   64'(csr_raddr), 64'(num));
    chk("wen",     64'(csr_wen), 64'(exp_wen));
    chk("rd_vld",  64'(csr_ecl_rdata_vld_m), 64'(m_live && !km));
    chk("stall_e", 64'(csr_ecl_stall_e), 64'(exp_stall));
    chk("flush",   64'(csr_ecl_flush_m), 64'(exp_wen && is_flush(m_addr)));
    if (m_live) chk("rdata_m", 64'(csr_ecl_rdata_m), 64'(m_old));
    if (exp_wen) begin
      chk("waddr", 64'(csr_waddr), 64'(m_addr));
      chk("wdata", 64'(csr_wdata), 64'(m_new));
      chk("mask",  64'(csr_mask), 64'(m_mask));
    end
  endtask

  // Advance the model and the CSR file across one rising edge.
  task automatic adv();
    logic               w;
    logic [CSR_BIT-1:0] wa;
    logic [GRLEN-1:0]   wd, wm, old_e;
    w = csr_wen; wa = csr_waddr; wd = csr_wdata; wm = csr_mask;
    old_e = ref_csr[e_num];
    if (exp_wen) ref_csr[m_addr] = (ref_csr[m_addr] & ~m_mask) | (m_new & m_mask);
    if (!e_sm) begin
      m_live = e_valid && !e_ke && !exp_stall;
      m_wr   = (e_op == 2'b01) || (e_op == 2'b10);
      m_done = 1'b0;
      m_addr = e_num;
      m_new  = e_rd;
      m_mask = op_mask(e_op, e_rj);
      m_old  = old_e;
    end else begin
      m_live = m_live && !ecl_csr_kill_m;
      m_done = m_done || exp_wen;
    end
    @(posedge clk);
    #1;
    if (w) begin
      mem[wa] = (mem[wa] & ~wm) | (wd & wm);
      n_wen++;
    end
  endtask

  task automatic idle(input logic km, input logic sm);
    cyc(1'b0, 2'b00, 14'h3ff, 32'h0, 32'h0, 1'b0, km, sm);
  endtask

  initial begin
    int c0;
    logic               v, ke, km, sm;
    logic [1:0]         op;
    logic [CSR_BIT-1:0] num;
    logic [GRLEN-1:0]   rd, rj;

    addrs[0] = 14'h000; addrs[1] = 14'h005; addrs[2] = 14'h006; addrs[3] = 14'h007;
    addrs[4] = 14'h00c; addrs[5] = 14'h041; addrs[6] = 14'h044; addrs[7] = 14'h001;
    for (int i = 0; i < 16384; i++) begin
      mem[i] = $urandom;
      ref_csr[i] = mem[i];
    end
    resetn = 1'b0;
    ecl_csr_op_valid_e = 1'b0; ecl_csr_op_e = 2'b00; ecl_csr_num_e = '0;
    exu_csr_rd_data_e = '0; exu_csr_rj_data_e = '0;
    ecl_csr_kill_e = 1'b0; ecl_csr_kill_m = 1'b0; ecl_stall_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", 64'(csr_wen), 64'(0));
    chk("rst_vld", 64'(csr_ecl_rdata_vld_m), 64'(0));
    resetn = 1'b1;

    // wr ERA: old 0x1234, new 0xDEAD0000, no flush.
    mem[6] = 32'h1234; ref_csr[6] = 32'h1234;
    cyc(1'b1, 2'b01, 14'h006, 32'hDEAD0000, 32'h0, 1'b0, 1'b0, 1'b0); adv();
    idle(1'b0, 1'b0);
    chk("era_wen", 64'(csr_wen), 64'(1));
    chk("era_mask", 64'(csr_mask), 64'(32'hFFFFFFFF));
    chk("era_wdata", 64'(csr_wdata), 64'(32'hDEAD0000));
    chk("era_rdata", 64'(csr_ecl_rdata_m), 64'(32'h1234));
    chk("era_flush", 64'(csr_ecl_flush_m), 64'(0));
    adv();

    // xchg CRMD: mask 0x4, flush.
    mem[0] = 32'h0; ref_csr[0] = 32'h0;
    cyc(1'b1, 2'b10, 14'h000, 32'h4, 32'h4, 1'b0, 1'b0, 1'b0); adv();
    idle(1'b0, 1'b0);
    chk("crmd_wen", 64'(csr_wen), 64'(1));
    chk("crmd_mask", 64'(csr_mask), 64'(32'h4));
    chk("crmd_flush", 64'(csr_ecl_flush_m), 64'(1));
    chk("crmd_rdata", 64'(csr_ecl_rdata_m), 64'(0));
    adv();

    // wr PRMD then rd PRMD back-to-back: one-cycle stall, new value read.
    c0 = n_wen;
    cyc(1'b1, 2'b01, 14'h001, 32'hA5A50001, 32'h0, 1'b0, 1'b0, 1'b0); adv();
    cyc(1'b1, 2'b00, 14'h001, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("prmd_stall", 64'(csr_ecl_stall_e), 64'(1));
    adv();
    cyc(1'b1, 2'b00, 14'h001, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("prmd_nostall", 64'(csr_ecl_stall_e), 64'(0));
    adv();
    idle(1'b0, 1'b0);
    chk("prmd_reread", 64'(csr_ecl_rdata_m), 64'(32'hA5A50001));
    adv();
    chk("prmd_wen_cnt", 64'(n_wen - c0), 64'(1));

    // wr EENTRY held in _m for three cycles: single write, stall drops after it.
    c0 = n_wen;
    cyc(1'b1, 2'b01, 14'h00c, 32'h1C000000, 32'h0, 1'b0, 1'b0, 1'b0); adv();
    cyc(1'b1, 2'b00, 14'h00c, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("eentry_wen1", 64'(csr_wen), 64'(1));
    chk("eentry_stall1", 64'(csr_ecl_stall_e), 64'(1));
    adv();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 2'b00, 14'h00c, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      chk("eentry_wen_held", 64'(csr_wen), 64'(0));
      chk("eentry_stall_held", 64'(csr_ecl_stall_e), 64'(0));
      adv();
    end
    cyc(1'b1, 2'b00, 14'h00c, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0); adv();
    idle(1'b0, 1'b0);
    chk("eentry_reread", 64'(csr_ecl_rdata_m), 64'(32'h1C000000));
    adv();
    chk("eentry_wen_cnt", 64'(n_wen - c0), 64'(1));

    // kill_m on a wr, kill_e bubble, reserved op.
    cyc(1'b1, 2'b01, 14'h005, 32'hFFFF, 32'h0, 1'b0, 1'b0, 1'b0); adv();
    idle(1'b1, 1'b0);
    chk("killm_wen", 64'(csr_wen), 64'(0));
    chk("killm_flush", 64'(csr_ecl_flush_m), 64'(0));
    chk("killm_vld", 64'(csr_ecl_rdata_vld_m), 64'(0));
    adv();
    cyc(1'b1, 2'b01, 14'h007, 32'h77, 32'h0, 1'b1, 1'b0, 1'b0); adv();
    idle(1'b0, 1'b0);
    chk("kille_vld", 64'(csr_ecl_rdata_vld_m), 64'(0));
    chk("kille_wen", 64'(csr_wen), 64'(0));
    adv();
    cyc(1'b1, 2'b11, 14'h007, 32'h99, 32'hFF, 1'b0, 1'b0, 1'b0); adv();
    idle(1'b0, 1'b0);
    chk("rsv_wen", 64'(csr_wen), 64'(0));
    chk("rsv_vld", 64'(csr_ecl_rdata_vld_m), 64'(1));
    adv();

    // Reset with a write pending in _m: outputs clear at once, write dropped.
    cyc(1'b1, 2'b01, 14'h041, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0); adv();
    ecl_csr_op_valid_e = 1'b1; ecl_csr_num_e = 14'h041;
    resetn = 1'b0;
    #1;
    chk("rstm_wen", 64'(csr_wen), 64'(0));
    chk("rstm_vld", 64'(csr_ecl_rdata_vld_m), 64'(0));
    chk("rstm_stall", 64'(csr_ecl_stall_e), 64'(0));
    chk("rstm_flush", 64'(csr_ecl_flush_m), 64'(0));
    chk("rstm_rdata", 64'(csr_ecl_rdata_m), 64'(0));
    chk("rstm_mask", 64'(csr_mask), 64'(0));
    m_live = 1'b0; m_done = 1'b0; exp_wen = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(1'b0, 1'b0);
    chk("rstm_nowrite", 64'(csr_wen), 64'(0));
    adv();

    // Random traffic; a stalled _e instruction is re-presented like the pipeline would.
    v = 1'b0; op = 2'b00; num = '0; rd = '0; rj = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!(e_valid && !e_ke && (exp_stall || e_sm))) begin
        v   = ($urandom_range(0, 3) != 0);
        op  = 2'($urandom_range(0, 3));
        num = addrs[$urandom_range(0, 7)];
        rd  = $urandom;
        rj  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      end
      ke = ($urandom_range(0, 7) == 0);
      km = ($urandom_range(0, 7) == 0);
      sm = ($urandom_range(0, 3) == 0);
      cyc(v, op, num, rd, rj, ke, km, sm);
      adv();
    end
    idle(1'b0, 1'b0); adv();

    for (int i = 0; i < 8; i++) chk("csr_state", 64'(mem[addrs[i]]), 64'(ref_csr[addrs[i]]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu7_csr_access.md
# cpu7_csr_access

CSR access initiator for the cpu7 pipeline: it drives the CSR file's read and write port on behalf of `csrrd`, `csrwr` and `csrxchg`.
- **_e stage:** issues the combinational read address.
- **_m stage:** registers the old value for writeback and issues exactly one masked write per retiring CSR instruction.
- **Hazards:** stalls _e on a same-address read-after-write.
- **Flush:** requests a pipeline flush after writes to CSRs that change fetch or interrupt state.

Sits between ecl/exu and the CSR file.

## Interface
- `GRLEN`, 32, data width.
- `CSR_BIT`, 14, CSR number width.
- `clk`  in  1  clock.
- `resetn`  in  1  asynchronous active-low reset.
- `ecl_csr_op_valid_e`  in  1  CSR instruction valid in _e.
- `ecl_csr_op_e`  in  2  00 rd, 01 wr, 10 xchg, 11 reserved (behaves as rd).
- `ecl_csr_num_e`  in  CSR_BIT  CSR number.
- `exu_csr_rd_data_e`  in  GRLEN  rd source value (new data).
- `exu_csr_rj_data_e`  in  GRLEN  rj value (xchg mask).
- `ecl_csr_kill_e`  in  1  kill the _e instruction.
- `ecl_csr_kill_m`  in  1  kill the _m instruction (exception/interrupt taken).
- `ecl_stall_m`  in  1  _m held this cycle.
- `csr_raddr`  out  CSR_BIT  read address, equals `ecl_csr_num_e`.
- `csr_rdata`  in  GRLEN  read data for `csr_raddr`.
- `csr_waddr`  out  CSR_BIT  write address (registered).
- `csr_wdata`  out  GRLEN  write data (registered).
- `csr_mask`  out  GRLEN  write mask (registered).
- `csr_wen`  out  1  write strobe.
- `csr_ecl_rdata_m`  out  GRLEN  old CSR value for rd writeback.
- `csr_ecl_rdata_vld_m`  out  1  _m holds a live CSR instruction.
- `csr_ecl_stall_e`  out  1  _e must hold (RAW hazard).
- `csr_ecl_flush_m`  out  1  refetch request after a flush-class write.

## Operation
- **Op decode at _e:**
  - rd: no write, mask 0.
  - wr: mask all ones, wdata = `rd_data`.
  - xchg: mask = `rj_data`, wdata = `rd_data`.
  - reserved 11: identical to rd.
- **Old value:** all ops return the pre-write `csr_rdata` to rd.
- **Capture into _m registers:** `vld_m`, `wr_m`, `waddr`, `wdata`, `mask`, `rdata_m`, `done_m`.
  - When `ecl_stall_m`=0: load with `vld_m <= ecl_csr_op_valid_e & ~ecl_csr_kill_e & ~csr_ecl_stall_e`. Other fields load unconditionally; they are don't-care when `vld_m`=0.
  - When `ecl_stall_m`=1: all _m registers hold, except `done_m` (below) and `vld_m`, which clears if `ecl_csr_kill_m`.
- **Write strobe:** `csr_wen = vld_m & wr_m & ~done_m & ~ecl_csr_kill_m`.
  - xchg with `rj`=0 still asserts `csr_wen`.
- **`done_m`:** set when `csr_wen` fires while `ecl_stall_m`=1; cleared on each _m advance. A held instruction therefore never writes twice.
- **`csr_ecl_rdata_vld_m`** = `vld_m & ~ecl_csr_kill_m`.
- **Hazard:** `csr_ecl_stall_e = ecl_csr_op_valid_e & vld_m & wr_m & ~done_m & (waddr == ecl_csr_num_e)`. The stalled _e instruction enters _m as a bubble and re-reads after the write lands.
- **Flush:**
  - `csr_ecl_flush_m = csr_wen` when `waddr` ∈ {0x0 CRMD, 0x5 ESTAT, 0xc EENTRY, 0x41 TCFG, 0x44 TICLR}.
  - Asserted for exactly one cycle per write.
- **Reset (async):**
  - `vld_m`, `wr_m`, `done_m`, `waddr`, `wdata`, `mask`, `rdata_m` = 0.
  - Hence `csr_wen`, `csr_ecl_rdata_vld_m`, `csr_ecl_stall_e`, `csr_ecl_flush_m` = 0.
  - `csr_raddr` follows its input.
- **Reset mid-operation:** a pending _m write is discarded, never issued.

## Timing
- Cycle N: _e read.
- Cycle N+1: `csr_wen` and `csr_ecl_rdata_m` valid. The CSR file updates at the end of N+1.
- Back-to-back same-address access:
  - Second op presented at N+1: stalled in N+1.
  - Re-read in N+2 returns the new value.
  - Total penalty: 1 cycle.
- Different-address ops issue back-to-back with no stall.
- `ecl_csr_kill_m` is combinational onto `csr_wen` and `csr_ecl_flush_m` in the same cycle.
- `csr_raddr` is combinational, zero latency.

## Test plan
- **wr to ERA (0x6), CSR old=0x1234, rd=0xDEAD0000:**
  - N+1: `csr_wen`=1, mask=0xFFFFFFFF, wdata=0xDEAD0000, `rdata_m`=0x1234.
  - N+1: `flush_m`=0.
- **xchg to CRMD, rj=0x4, rd=0x4, old=0x0:**
  - N+1: `csr_wen`=1, mask=0x4, `flush_m`=1, `rdata_m`=0.
- **wr PRMD at N, rd PRMD at N+1:**
  - N+1: `stall_e`=1.
  - N+2: read returns the written value.
  - Exactly one `csr_wen` pulse.
- **wr EENTRY enters _m with `ecl_stall_m`=1 for 3 cycles:**
  - `csr_wen` high the first cycle only.
  - `rdata_m` held throughout.
  - `stall_e` drops after the write fires.
- **Kill handling:**
  - `ecl_csr_kill_m`=1 during _m of a wr: `csr_wen`=0, `flush_m`=0, `rdata_vld_m`=0.
  - `ecl_csr_kill_e`=1: the next _m is a bubble.
- **Reset and reserved op:**
  - `resetn` low with a wr pending in _m: all outputs 0 immediately; no write after release.
  - op=11: behaves as rd, `csr_wen`=0.
